gray_counter_ud: RTL and testbench

Parametrised up/down Gray-code counter with enable, synchronous clear and load, a programmable terminal value, and wrap or saturate mode. It produces a registered Gray code, the matching binary count, a zero flag, a terminal-count indication and a wrap pulse. It serves as the common counter/pointer source for clock-domain-crossing pointers and timers. It is the formal-checkable successor of the fixed 9-bit free-running Gray counter.

---
 rtl/gray_counter_ud.sv | 135 +++++++++++++
 tb/tb_gray_counter_ud.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/gray_counter_ud.sv
// ---------------------------------------------------------------------------
// gray_counter_ud
// Parametrised up/down Gray-code counter with enable, synchronous clear and
// load, a programmable terminal value (MAX_VAL) and wrap/saturate behaviour.
// Gray code is derived from the next binary value and registered on the same
// edge as the binary count, so gray_c always matches bin_cnt with no lag.
//
// Optional build macro: GRAY_CNT_SVA_EN
//   defined   -> embedded concurrent assertions are compiled in
//   undefined -> no properties, identical RTL behaviour
// ---------------------------------------------------------------------------
module gray_counter_ud #(
   parameter int               WIDTH    = 9,
   parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
   parameter int               SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] bin_cnt,
   output logic [WIDTH-1:0] gray_c,
   output logic             zero,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ZERO = '0;

   // Loaded values beyond the terminal value are pinned to it.
   function automatic logic [WIDTH-1:0] f_clamp(input logic [WIDTH-1:0] v);
      return (v > MAX_VAL) ? MAX_VAL : v;
   endfunction

   // Reflected binary Gray code of a binary value.
   function automatic logic [WIDTH-1:0] f_bin2gray(input logic [WIDTH-1:0] v);
      return v ^ (v >> 1);
   endfunction

   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] r_gray;
   logic             r_wrap;

   logic             w_at_max;
   logic             w_at_min;
   logic [WIDTH-1:0] w_bin_nxt;
   logic             w_wrap_nxt;

   assign w_at_max = (r_bin == MAX_VAL);
   assign w_at_min = (r_bin == ZERO);

   // Next-count selection: clr > load > en > hold; range ends are tested
   // before the increment/decrement so the arithmetic never overflows.
   always_comb begin
      w_bin_nxt  = r_bin;
      w_wrap_nxt = 1'b0;
      if (clr) begin
         w_bin_nxt = ZERO;
      end else if (load) begin
         w_bin_nxt = f_clamp(load_val);
      end else if (en) begin
         if (up) begin
            if (w_at_max) begin
               if (SATURATE != 0) begin
                  w_bin_nxt = MAX_VAL;
               end else begin
                  w_bin_nxt  = ZERO;
                  w_wrap_nxt = 1'b1;
               end
            end else begin
               w_bin_nxt = r_bin + ONE;
            end
         end else begin
            if (w_at_min) begin
               if (SATURATE != 0) begin
                  w_bin_nxt = ZERO;
               end else begin
                  w_bin_nxt  = MAX_VAL;
                  w_wrap_nxt = 1'b1;
               end
            end else begin
               w_bin_nxt = r_bin - ONE;
            end
         end
      end
   end

   // Count, Gray code and wrap pulse registers; reset clears them at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bin  <= ZERO;
         r_gray <= ZERO;
         r_wrap <= 1'b0;
      end else begin
         r_bin  <= w_bin_nxt;
         r_gray <= f_bin2gray(w_bin_nxt);
         r_wrap <= w_wrap_nxt;
      end
   end

   assign bin_cnt = r_bin;
   assign gray_c  = r_gray;
   assign wrap    = r_wrap;
   assign zero    = w_at_min & ~rst;
   assign tc      = en & (up ? w_at_max : w_at_min);

`ifdef GRAY_CNT_SVA_EN
   a_gray_match : assert property (@(posedge clk) disable iff (rst)
      gray_c == (bin_cnt ^ (bin_cnt >> 1)));

   a_in_range : assert property (@(posedge clk) disable iff (rst)
      bin_cnt <= MAX_VAL);

   a_leave_zero : assert property (@(posedge clk) disable iff (rst)
      (zero && !rst && en && up && !clr && !load) |=> !zero);

   a_wrap_tc : assert property (@(posedge clk) disable iff (rst)
      wrap |-> $past(tc));

   // One-bit change only holds when the range is a full power of two.
   generate
      if (MAX_VAL == {WIDTH{1'b1}}) begin : g_one_bit
         a_one_bit : assert property (@(posedge clk) disable iff (rst)
            (en && !clr && !load) |=> ($countones(gray_c ^ $past(gray_c)) <= 1));
      end
   endgenerate
`else
   // Property checking not compiled in this build.
`endif

endmodule

// File: tb/tb_gray_counter_ud.sv
// ---------------------------------------------------------------------------
// tb_gray_counter_ud
// Three 4-bit instances share one stimulus stream: wrap (MAX_VAL=15),
// saturate (MAX_VAL=15) and wrap with a short range (MAX_VAL=9). A reference
// model built from the counting rules is checked every cycle; a vector table
// and hand sequences pin down the specific corner cases.
// ---------------------------------------------------------------------------
module tb_gray_counter_ud;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst      = 1'b1;
   logic       en       = 1'b0;
   logic       up       = 1'b0;
   logic       clr      = 1'b0;
   logic       load     = 1'b0;
   logic [3:0] load_val = 4'd0;

   logic [3:0] bin  [3];
   logic [3:0] gray [3];
   logic       zero [3];
   logic       tc   [3];
   logic       wrap [3];

   gray_counter_ud #(.WIDTH(4), .MAX_VAL(4'd15), .SATURATE(0)) u_wrap (
      .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
      .load_val(load_val), .bin_cnt(bin[0]), .gray_c(gray[0]),
      .zero(zero[0]), .tc(tc[0]), .wrap(wrap[0]));

   gray_counter_ud #(.WIDTH(4), .MAX_VAL(4'd15), .SATURATE(1)) u_sat (
      .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
      .load_val(load_val), .bin_cnt(bin[1]), .gray_c(gray[1]),
      .zero(zero[1]), .tc(tc[1]), .wrap(wrap[1]));

   gray_counter_ud #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(0)) u_short (
      .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
      .load_val(load_val), .bin_cnt(bin[2]), .gray_c(gray[2]),
      .zero(zero[2]), .tc(tc[2]), .wrap(wrap[2]));

   int maxv [3] = '{15, 15, 9};
   int satv [3] = '{0, 1, 0};

   int m_cnt  [3] = '{0, 0, 0};
   int m_wrap [3] = '{0, 0, 0};

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       v_en, v_up, v_clr, v_load;
      logic [3:0] v_lv;
      int         idx;
      int         e_bin, e_gray, e_wrap;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: next count from the counting rules in plain integer arithmetic.
   task automatic model_step();
      for (int k = 0; k < 3; k++) begin
         int c = m_cnt[k];
         int n = c;
         int w = 0;
         if (clr) n = 0;
         else if (load) n = (int'(load_val) > maxv[k]) ? maxv[k] : int'(load_val);
         else if (en) begin
            if (up) begin
               if (c == maxv[k]) begin
                  if (satv[k] != 0) n = c; else begin n = 0; w = 1; end
               end else n = c + 1;
            end else begin
               if (c == 0) begin
                  if (satv[k] != 0) n = 0; else begin n = maxv[k]; w = 1; end
               end else n = c - 1;
            end
         end
         m_cnt[k]  = n;
         m_wrap[k] = w;
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_cnt[k]  = 0;
         m_wrap[k] = 0;
      end
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s.bin%0d", tag, k),  32'(bin[k]),  32'(m_cnt[k]));
         chk($sformatf("%s.gray%0d", tag, k), 32'(gray[k]), 32'(m_cnt[k] ^ (m_cnt[k] >> 1)));
         chk($sformatf("%s.zero%0d", tag, k), 32'(zero[k]), 32'((m_cnt[k] == 0) && !rst));
         chk($sformatf("%s.tc%0d", tag, k),   32'(tc[k]),
             32'(en && (up ? (m_cnt[k] == maxv[k]) : (m_cnt[k] == 0))));
         chk($sformatf("%s.wrap%0d", tag, k), 32'(wrap[k]), 32'(m_wrap[k]));
      end
   endtask

   // One clock: drive inputs, check at the falling edge, advance the model.
   task automatic cycle(input logic i_en, input logic i_up, input logic i_clr,
                        input logic i_load, input logic [3:0] i_lv, input string tag);
      en = i_en; up = i_up; clr = i_clr; load = i_load; load_val = i_lv;
      @(negedge clk);
      check_all(tag);
      @(posedge clk);
      model_step();
      #1;
   endtask

   function automatic vec_t mk(input logic a_en, input logic a_up, input logic a_clr,
                               input logic a_load, input logic [3:0] a_lv, input int a_idx,
                               input int a_bin, input int a_gray, input int a_wrap);
      vec_t v;
      v.v_en = a_en; v.v_up = a_up; v.v_clr = a_clr; v.v_load = a_load; v.v_lv = a_lv;
      v.idx = a_idx; v.e_bin = a_bin; v.e_gray = a_gray; v.e_wrap = a_wrap;
      return v;
   endfunction

   initial begin
      //            en    up    clr   load  lv     dut bin gray wrap
      tbl[0]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd14, 1, 14, 9, 0);
      tbl[1]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  1, 15, 8, 0);
      tbl[2]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  1, 15, 8, 0);
      tbl[3]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  1, 15, 8, 0);
      tbl[4]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd12, 2, 9, 13, 0);
      tbl[5]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  2, 0, 0, 1);
      tbl[6]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd5,  0, 5, 7, 0);
      tbl[7]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 4'd3,  0, 0, 0, 0);
      tbl[8]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 4'd7,  0, 7, 4, 0);
      tbl[9]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  0, 6, 5, 0);
      tbl[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  0, 0, 0, 0);
      tbl[11] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  0, 15, 8, 1);
      tbl[12] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  0, 14, 9, 0);
      tbl[13] = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  0, 15, 8, 0);
      tbl[14] = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  0, 0, 0, 1);

      // Held in reset across two edges: everything must read zero.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all("reset");
      @(posedge clk);
      #1 rst = 1'b0;

      // Free count up from reset release: 1..15 then back to 0 with wrap.
      for (int i = 1; i <= 16; i++) begin
         cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "upseq");
         chk($sformatf("upseq_bin_%0d", i), 32'(bin[0]), 32'(i % 16));
         chk($sformatf("upseq_wrap_%0d", i), 32'(wrap[0]), 32'(i == 16));
      end

      // Directed vector table.
      for (int t = 0; t < 15; t++) begin
         cycle(tbl[t].v_en, tbl[t].v_up, tbl[t].v_clr, tbl[t].v_load, tbl[t].v_lv,
               $sformatf("vec%0d", t));
         chk($sformatf("vec%0d_bin", t),  32'(bin[tbl[t].idx]),  32'(tbl[t].e_bin));
         chk($sformatf("vec%0d_gray", t), 32'(gray[tbl[t].idx]), 32'(tbl[t].e_gray));
         chk($sformatf("vec%0d_wrap", t), 32'(wrap[tbl[t].idx]), 32'(tbl[t].e_wrap));
      end

      // Asynchronous reset in the middle of a cycle at count 11.
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd11, "preload");
      chk("pre_async_bin", 32'(bin[0]), 32'd11);
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("async_bin", 32'(bin[0]), 32'd0);
      chk("async_gray", 32'(gray[0]), 32'd0);
      chk("async_zero", 32'(zero[0]), 32'd0);
      check_all("async");
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("release_zero", 32'(zero[0]), 32'd1);
      check_all("release");

      // Randomised traffic checked against the model on every cycle.
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1,
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) == 0),
               4'($urandom_range(0, 15)), "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
